ahb_arbiter: RTL

- Central AHB bus arbiter for the FreeAHB system; shares one AHB address/data bus among up to 16 ahb_master instances.
- Master index i uses MASTER_ID i.
- Takes per-master bus requests, lock requests and slave split-resume strobes; drives one-hot grants plus the address-phase and data-phase owner IDs.
- Sits between the masters' o_hbusreq/o_hlock and their i_hgrant/i_hmaster inputs.
- Policy: round-robin with bounded tenure, lock support and SPLIT masking.

---
 rtl/ahb_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
// FreeAHB central bus arbiter: round-robin grant with bounded tenure, HLOCK hold and SPLIT masking.
// Define AHB_ARB_SPLIT_EN to build the split-mask logic; when undefined SPLIT behaves like RETRY.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input  logic                   i_hclk,
  input  logic                   i_hreset,
  input  logic [NUM_MASTERS-1:0] i_hbusreq,
  input  logic [NUM_MASTERS-1:0] i_hlock,
  input  logic [1:0]             i_htrans,
  input  logic                   i_hready,
  input  logic [1:0]             i_hresp,
  input  logic [NUM_MASTERS-1:0] i_hsplit,
  output logic [NUM_MASTERS-1:0] o_hgrant,
  output logic [3:0]             o_hmaster,
  output logic [3:0]             o_hmaster_data,
  output logic                   o_hmastlock,
  output logic [NUM_MASTERS-1:0] o_split_mask
);

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;
  localparam int         TW            = (MAX_TENURE > 2) ? $clog2(MAX_TENURE) : 1;
  // Unlimited tenure still needs a saturation point for the (then unused) counter.
  localparam int         TEN_SAT       = (MAX_TENURE == 0) ? ((1 << TW) - 1)
                                                           : ((MAX_TENURE > 0) ? MAX_TENURE - 1 : 0);
  localparam logic [3:0] DEF_ID        = 4'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             owner_q, owner_d;
  logic [3:0]             hmaster_q, hmaster_d;
  logic [3:0]             hmaster_data_q, hmaster_data_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [TW-1:0]          tenure_q, tenure_d;
  logic [NUM_MASTERS-1:0] mask_eff;
  logic                   split_owner;
  logic [NUM_MASTERS-1:0] cand;
  logic                   owner_locked, owner_req, tenure_ok, beat_active;
  int                     rr_dist, rr_best;
  logic [3:0]             rr_idx;

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
  logic                   split_hit;

  always_comb begin
    split_hit    = i_hready && (i_hresp == HRESP_SPLIT);
    split_mask_d = split_mask_q & ~i_hsplit;
    // Setting after clearing makes a same-cycle set win over a resume strobe.
    if (split_hit && hmaster_data_q != DEF_ID) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (hmaster_data_q == 4'(i)) split_mask_d[i] = 1'b1;
      end
    end
    split_mask_d[DEFAULT_MASTER] = 1'b0;
    mask_eff                     = split_mask_q;
    mask_eff[DEFAULT_MASTER]     = 1'b0;
    split_owner                  = split_hit && (hmaster_data_q == owner_q);
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) split_mask_q <= '0;
    else          split_mask_q <= split_mask_d;
  end

  assign o_split_mask = split_mask_q;
`else
  logic unused_split;
  assign unused_split = ^{i_hsplit, i_hresp};
  assign mask_eff     = '0;
  assign split_owner  = 1'b0;
  assign o_split_mask = '0;
`endif

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    cand         = i_hbusreq & ~mask_eff & ~(split_owner ? grant_q : '0);
    owner_locked = |(i_hlock & grant_q);
    owner_req    = |(cand & grant_q);
    tenure_ok    = (MAX_TENURE == 0) || (int'(tenure_q) < TEN_SAT);
    beat_active  = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);

    // Round-robin: smallest forward distance from owner+1, with the owner itself last.
    rr_best = NUM_MASTERS;
    rr_idx  = DEF_ID;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rr_dist = i - int'(owner_q) - 1;
      if (rr_dist < 0) rr_dist = rr_dist + NUM_MASTERS;
      if (cand[i] && rr_dist < rr_best) begin
        rr_best = rr_dist;
        rr_idx  = 4'(i);
      end
    end

    owner_d        = owner_q;
    grant_d        = grant_q;
    tenure_d       = tenure_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    hmastlock_d    = hmastlock_q;

    if (i_hready) begin
      if (!split_owner && hmastlock_q && owner_locked) owner_d = owner_q;
      else if (owner_req && tenure_ok)                 owner_d = owner_q;
      else if (|cand)                                  owner_d = rr_idx;
      else                                             owner_d = DEF_ID;

      for (int i = 0; i < NUM_MASTERS; i++) grant_d[i] = (owner_d == 4'(i));

      if (owner_d != owner_q)                                 tenure_d = '0;
      else if (beat_active && int'(tenure_q) < TEN_SAT)       tenure_d = tenure_q + TW'(1);

      hmaster_d      = owner_q;
      hmaster_data_d = hmaster_q;
      hmastlock_d    = owner_locked;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      grant_q        <= '0;
      grant_q[DEFAULT_MASTER] <= 1'b1;
      owner_q        <= DEF_ID;
      hmaster_q      <= DEF_ID;
      hmaster_data_q <= DEF_ID;
      hmastlock_q    <= 1'b0;
      tenure_q       <= '0;
    end else begin
      grant_q        <= grant_d;
      owner_q        <= owner_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
      tenure_q       <= tenure_d;
    end
  end

  assign o_hgrant       = grant_q;
  assign o_hmaster      = hmaster_q;
  assign o_hmaster_data = hmaster_data_q;
  assign o_hmastlock    = hmastlock_q;

endmodule
